// File: rtl/half_adder_if.sv
// ----------------------------------------------------------------------------
// half_adder_if
//   Bundles the operand, result and valid signals of the half adder.
//   master : drives A, B and in_valid. Samples the combinational and
//            registered results.
//   slave  : the adder itself. Samples A, B and in_valid. Drives S, Cout,
//            S_q, Cout_q and out_valid.
// Signals
//   A, B      [WIDTH]  operands, bit i feeds slice i
//   in_valid  1        A/B qualified for the registered path
//   S, Cout   [WIDTH]  combinational sum / carry
//   S_q, Cout_q [WIDTH] registered sum / carry
//   out_valid 1        S_q/Cout_q hold a result this cycle
// ----------------------------------------------------------------------------
interface half_adder_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic [WIDTH-1:0] S;
    logic [WIDTH-1:0] Cout;
    logic [WIDTH-1:0] S_q;
    logic [WIDTH-1:0] Cout_q;
    logic             out_valid;

    modport master (
        output A, B, in_valid,
        input  S, Cout, S_q, Cout_q, out_valid
    );

    modport slave (
        input  A, B, in_valid,
        output S, Cout, S_q, Cout_q, out_valid
    );
endinterface

// File: rtl/half_adder.sv
// ----------------------------------------------------------------------------
// half_adder
//   Bit-parallel half adder with two result paths.
//   - Combinational: S = A ^ B, Cout = A & B, per slice.
//   - Registered: one-cycle latency, qualified by out_valid.
//   Also keeps a saturating count of accepted operations that carried in
//   any slice.
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        half_adder_if.slave (A, B, in_valid, S, Cout, S_q, Cout_q,
//              out_valid)
//   clr_cnt    synchronous clear of carry_cnt. Overrides an increment.
//   carry_cnt  accepted ops with |(A&B), saturating at all-ones
// ----------------------------------------------------------------------------
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    half_adder_if.slave      bus,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] carry_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] sum_c;
    logic [WIDTH-1:0] carry_c;
    logic             any_carry;

    // Slices are independent, so bitwise operators give per-slice results.
    // No carry ripples between bits. An X on one operand bit stays in that
    // slice.
    assign sum_c     = bus.A ^ bus.B;
    assign carry_c   = bus.A & bus.B;
    assign any_carry = |carry_c;

    assign bus.S     = sum_c;
    assign bus.Cout  = carry_c;

    // Registered path. When in_valid is low, the data registers hold their
    // last values. Consumers only look at them while out_valid is set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.S_q       <= '0;
            bus.Cout_q    <= '0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.S_q    <= sum_c;
                bus.Cout_q <= carry_c;
            end
        end
    end

    // Carry-event counter. A clear wins over an increment on the same edge.
    // The counter stops at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_cnt <= '0;
        end else if (clr_cnt) begin
            carry_cnt <= '0;
        end else if (bus.in_valid && any_carry && (carry_cnt != CNT_MAX)) begin
            carry_cnt <= carry_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_half_adder.sv
// ----------------------------------------------------------------------------
// tb_half_adder
//   dut8 : WIDTH=8, CNT_W=16. Gets directed and random traffic, checked
//          every cycle against the reference model.
//   dut1 : WIDTH=1, CNT_W=2. Used for the truth table, the single-slice
//          registered case and counter saturation.
// ----------------------------------------------------------------------------
module tb_half_adder;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;

    logic        clr8 = 1'b0;
    logic        clr1 = 1'b0;
    logic [15:0] cnt8;
    logic [1:0]  cnt1;

    int n_vec = 0;
    int n_bad = 0;

    half_adder_if #(.WIDTH(8)) bus8 ();
    half_adder_if #(.WIDTH(1)) bus1 ();

    half_adder #(.WIDTH(8), .CNT_W(16)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus8),
        .clr_cnt   (clr8),
        .carry_cnt (cnt8)
    );

    half_adder #(.WIDTH(1), .CNT_W(2)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1),
        .clr_cnt   (clr1),
        .carry_cnt (cnt1)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-slice arithmetic: the two operand bits add as small integers.
    // The sum bit is the value mod 2. The carry bit is the value div 2.
    function automatic void ref_add(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] s, output logic [7:0] c);
        for (int i = 0; i < 8; i++) begin
            int t;
            t    = int'(a[i]) + int'(b[i]);
            s[i] = (t % 2) == 1;
            c[i] = (t / 2) == 1;
        end
    endfunction

    // Reference model for dut8's registered path and counter.
    logic [7:0] m_sq = '0;
    logic [7:0] m_cq = '0;
    logic       m_ov = 1'b0;
    int         m_cnt = 0;

    always @(posedge clk or negedge rst_n) begin
        logic [7:0] s, c;
        if (!rst_n) begin
            m_sq  = '0;
            m_cq  = '0;
            m_ov  = 1'b0;
            m_cnt = 0;
        end else begin
            ref_add(bus8.A, bus8.B, s, c);
            m_ov = bus8.in_valid;
            if (bus8.in_valid) begin
                m_sq = s;
                m_cq = c;
            end
            if (clr8)
                m_cnt = 0;
            else if (bus8.in_valid && c != 8'h00 && m_cnt < 65535)
                m_cnt = m_cnt + 1;
        end
    end

    // Compare process, half a cycle away from the active edge.
    always @(negedge clk) begin
        logic [7:0] s, c;
        if (chk_en) begin
            ref_add(bus8.A, bus8.B, s, c);
            chk("S",         32'(bus8.S),         32'(s));
            chk("Cout",      32'(bus8.Cout),      32'(c));
            chk("out_valid", 32'(bus8.out_valid), 32'(m_ov));
            if (m_ov) begin
                chk("S_q",    32'(bus8.S_q),    32'(m_sq));
                chk("Cout_q", 32'(bus8.Cout_q), 32'(m_cq));
            end
            chk("carry_cnt", 32'(cnt8), 32'(m_cnt));
        end
    end

    task automatic step8(input logic iv, input logic [7:0] a, input logic [7:0] b, input logic clr);
        @(negedge clk);
        #1;
        bus8.in_valid = iv;
        bus8.A        = a;
        bus8.B        = b;
        clr8          = clr;
    endtask

    task automatic step1(input logic iv, input logic a, input logic b, input logic clr);
        @(negedge clk);
        #1;
        bus1.in_valid = iv;
        bus1.A        = a;
        bus1.B        = b;
        clr1          = clr;
    endtask

    logic [1:0] exp_cs [4] = '{2'b00, 2'b01, 2'b01, 2'b10};

    initial begin
        bus8.A = '0; bus8.B = '0; bus8.in_valid = 1'b0;
        bus1.A = '0; bus1.B = '0; bus1.in_valid = 1'b0;

        // Truth table with no clock running and reset held.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = 2'(i);
            bus1.A = ab[1];
            bus1.B = ab[0];
            #10;
            chk("tt_cout_s", 32'({bus1.Cout, bus1.S}), 32'(exp_cs[i]));
        end
        bus8.A = 8'hF0;
        bus8.B = 8'hCC;
        #1;
        chk("w8_S",    32'(bus8.S),    32'h3C);
        chk("w8_Cout", 32'(bus8.Cout), 32'hC0);
        chk("rst_ov8", 32'(bus8.out_valid), 32'd0);
        chk("rst_sq8", 32'(bus8.S_q),       32'd0);
        chk("rst_cq8", 32'(bus8.Cout_q),    32'd0);
        chk("rst_cnt8", 32'(cnt8),          32'd0);
        chk("rst_cnt1", 32'(cnt1),          32'd0);
        bus8.A = '0;
        bus8.B = '0;
        #3;
        rst_n  = 1'b1;
        clk_en = 1'b1;
        chk_en = 1'b1;

        // Single-slice registered path.
        step1(1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("r1_S_q",   32'(bus1.S_q),       32'd0);
        chk("r1_Cout_q", 32'(bus1.Cout_q),   32'd1);
        chk("r1_ov",    32'(bus1.out_valid), 32'd1);
        bus1.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("r1_ov_drop", 32'(bus1.out_valid), 32'd0);

        // 8-bit registered result.
        step8(1'b1, 8'hF0, 8'hCC, 1'b0);
        @(posedge clk); #1;
        chk("r8_S_q",    32'(bus8.S_q),       32'h3C);
        chk("r8_Cout_q", 32'(bus8.Cout_q),    32'hC0);
        chk("r8_ov",     32'(bus8.out_valid), 32'd1);

        // Counter: clear, then 11, 01, 11 gives 2. A clear with a carrying
        // op gives 0.
        step8(1'b0, 8'h00, 8'h00, 1'b1);
        step8(1'b1, 8'h01, 8'h01, 1'b0);
        step8(1'b1, 8'h00, 8'h01, 1'b0);
        step8(1'b1, 8'h01, 8'h01, 1'b0);
        @(posedge clk); #1;
        chk("cnt_two", 32'(cnt8), 32'd2);
        step8(1'b1, 8'hFF, 8'hFF, 1'b1);
        @(posedge clk); #1;
        chk("cnt_clr_prio", 32'(cnt8), 32'd0);
        step8(1'b0, 8'h00, 8'h00, 1'b0);

        // Saturation on the 2-bit counter.
        step1(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step1(1'b1, 1'b1, 1'b1, 1'b0);
        @(posedge clk); #1;
        chk("cnt_sat", 32'(cnt1), 32'd3);
        bus1.in_valid = 1'b0;

        // Random traffic on dut8.
        for (int i = 0; i < 400; i++) begin
            step8($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom),
                  $urandom_range(0, 15) == 0);
        end

        // Asynchronous reset between edges while a result is valid.
        step8(1'b1, 8'h03, 8'h01, 1'b0);
        @(posedge clk); #2;
        chk("ar_pre_ov", 32'(bus8.out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar_ov",     32'(bus8.out_valid), 32'd0);
        chk("ar_S_q",    32'(bus8.S_q),       32'd0);
        chk("ar_Cout_q", 32'(bus8.Cout_q),    32'd0);
        chk("ar_cnt",    32'(cnt8),           32'd0);
        step8(1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++) begin
            step8($urandom_range(0, 1) != 0, 8'($urandom), 8'($urandom), 1'b0);
        end
        step8(1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
